// File: rtl/reg_bank16.sv
// 16-entry register bank with two combinational read ports, one write port and a
// valid/ready dump engine that streams every entry out for debug.
module reg_bank16 #(
    parameter int WIDTH   = 32,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [3:0]       raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             we,
    input  logic [3:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             dump_start,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [3:0]       dump_idx,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_busy,
    output logic             dump_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [WIDTH-1:0] regs_q [16];
    logic [1:0]       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             wr_ok_s;

    // R0 forces zero even over a bypass hit; otherwise a live write wins over storage.
    function automatic logic [WIDTH-1:0] sel_word(
        input logic [3:0]       addr,
        input logic [WIDTH-1:0] stored,
        input logic             wr_ok,
        input logic [3:0]       wa,
        input logic [WIDTH-1:0] wd
    );
        if (ZERO_R0 && (addr == 4'd0)) begin
            sel_word = {WIDTH{1'b0}};
        end else if (wr_ok && (wa == addr)) begin
            sel_word = wd;
        end else begin
            sel_word = stored;
        end
    endfunction

    assign wr_ok_s = we && !(ZERO_R0 && (waddr == 4'd0));

    // Register storage: cleared on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Read ports and dump word share the same bypass/R0 resolution.
    always_comb begin
        rdata_a   = sel_word(raddr_a, regs_q[raddr_a], wr_ok_s, waddr, wdata);
        rdata_b   = sel_word(raddr_b, regs_q[raddr_b], wr_ok_s, waddr, wdata);
        dump_data = sel_word(idx_q, regs_q[idx_q], wr_ok_s, waddr, wdata);
    end

    // Dump sequencer next-state: start only from IDLE, advance on each handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    state_d = ST_SEND;
                    idx_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (dump_ready) begin
                    if (idx_q == 4'd15) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    // Dump sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Handshake/status outputs decode straight from the state register.
    always_comb begin
        dump_valid = (state_q == ST_SEND);
        dump_busy  = (state_q != ST_IDLE);
        dump_done  = (state_q == ST_DONE);
        dump_idx   = idx_q;
    end

endmodule

// File: tb/tb_reg_bank16.sv
// Self-checking bench for reg_bank16: read/write, R0 handling and dump engine,
// with a scoreboard queue of expected dump words.
module tb_reg_bank16;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  raddr_a, raddr_b, waddr;
    logic [31:0] rdata_a, rdata_b, wdata, dump_data;
    logic        we, dump_start, dump_ready, dump_valid, dump_busy, dump_done;
    logic [3:0]  dump_idx;
    logic [31:0] rdata_a_nz, rdata_b_nz, dump_data_nz;
    logic        dump_valid_nz, dump_busy_nz, dump_done_nz;
    logic [3:0]  dump_idx_nz;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] model [16];
    exp_t        sb [$];

    always #5 clk = ~clk;

    reg_bank16 #(.WIDTH(32), .ZERO_R0(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .we(we), .waddr(waddr), .wdata(wdata),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
    );

    reg_bank16 #(.WIDTH(32), .ZERO_R0(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n),
        .raddr_a(raddr_a), .rdata_a(rdata_a_nz), .raddr_b(raddr_b), .rdata_b(rdata_b_nz),
        .we(we), .waddr(waddr), .wdata(wdata),
        .dump_start(dump_start), .dump_valid(dump_valid_nz), .dump_ready(dump_ready),
        .dump_idx(dump_idx_nz), .dump_data(dump_data_nz), .dump_busy(dump_busy_nz),
        .dump_done(dump_done_nz)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        step();
        we    = 1'b1;
        waddr = a;
        wdata = d;
        if (a != 4'd0) model[a] = d;
    endtask

    task automatic push_all();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.idx  = 4'(i);
            e.data = model[i];
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        write_reg(4'd5, 32'h0000_AAAA);
        write_reg(4'd9, 32'h0000_BBBB);
        step();
        we = 1'b0; dump_start = 1'b1; dump_ready = 1'b0;
        step();
        dump_start = 1'b0;
        raddr_a = 4'd5; raddr_b = 4'd9;
        #1;
        total_cnt++;
        if (dump_busy !== 1'b1 || rdata_a !== 32'h0000_AAAA || rdata_b !== 32'h0000_BBBB)
            $display("FAIL pre_reset: busy=%b a=%h b=%h want 1 0000aaaa 0000bbbb", dump_busy, rdata_a, rdata_b);
        else pass_cnt++;
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0 || rdata_a_nz !== 32'h0)
            $display("FAIL reset_reads: a=%h b=%h a_nz=%h want 0", rdata_a, rdata_b, rdata_a_nz);
        else pass_cnt++;
        total_cnt++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_done !== 1'b0 || dump_idx !== 4'd0 || dump_data !== 32'h0 || dump_busy_nz !== 1'b0)
            $display("FAIL reset_dump: busy=%b valid=%b done=%b idx=%0d data=%h want 0 0 0 0 0",
                     dump_busy, dump_valid, dump_done, dump_idx, dump_data);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        step();
        we = 1'b1; waddr = 4'd5; wdata = 32'hDEAD_BEEF; raddr_a = 4'd5; raddr_b = 4'd6;
        model[5] = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if (rdata_a !== 32'hDEAD_BEEF) $display("FAIL bypass_a: got %h want deadbeef", rdata_a);
        else pass_cnt++;
        total_cnt++;
        if (rdata_b !== 32'h0) $display("FAIL read_b6: got %h want 0", rdata_b);
        else pass_cnt++;
        step();
        we = 1'b0;
        #1;
        total_cnt++;
        if (rdata_a !== model[5]) $display("FAIL stored_a: got %h want %h", rdata_a, model[5]);
        else pass_cnt++;
        step();
        raddr_b = 4'd5;
        #1;
        total_cnt++;
        if (rdata_a !== model[5] || rdata_b !== model[5])
            $display("FAIL same_addr: a=%h b=%h want %h", rdata_a, rdata_b, model[5]);
        else pass_cnt++;
    endtask

    task automatic test_r0();
        step();
        we = 1'b1; waddr = 4'd0; wdata = 32'h1234_5678; raddr_a = 4'd0;
        #1;
        total_cnt++;
        if (rdata_a !== 32'h0) $display("FAIL r0_bypass: got %h want 0", rdata_a);
        else pass_cnt++;
        total_cnt++;
        if (rdata_a_nz !== 32'h1234_5678) $display("FAIL r0_nz_bypass: got %h want 12345678", rdata_a_nz);
        else pass_cnt++;
        step();
        we = 1'b0;
        #1;
        total_cnt++;
        if (rdata_a !== 32'h0) $display("FAIL r0_after: got %h want 0", rdata_a);
        else pass_cnt++;
        total_cnt++;
        if (rdata_a_nz !== 32'h1234_5678) $display("FAIL r0_nz_after: got %h want 12345678", rdata_a_nz);
        else pass_cnt++;
    endtask

    task automatic test_dump();
        exp_t e;
        int   xfers = 0;
        for (int i = 1; i < 16; i++) write_reg(4'(i), 32'(i) * 32'h1111);
        push_all();
        step();
        we = 1'b0; dump_start = 1'b1; dump_ready = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            step();
            dump_start = 1'b0;
            #1;
            if (cyc < 16) begin
                total_cnt++;
                if (dump_valid !== 1'b1) $display("FAIL dump_valid_c%0d: got %b want 1", cyc, dump_valid);
                else pass_cnt++;
            end
            if (dump_valid === 1'b1) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL dump_extra: idx=%0d data=%h want no transfer", dump_idx, dump_data);
                end else begin
                    e = sb.pop_front();
                    if (dump_idx !== e.idx || dump_data !== e.data)
                        $display("FAIL dump_word: idx=%0d data=%h want idx=%0d data=%h", dump_idx, dump_data, e.idx, e.data);
                    else pass_cnt++;
                end
                xfers++;
            end
            if (cyc == 16) begin
                total_cnt++;
                if (dump_done !== 1'b1 || dump_valid !== 1'b0 || xfers != 16)
                    $display("FAIL dump_done: done=%b valid=%b xfers=%0d want 1 0 16", dump_done, dump_valid, xfers);
                else pass_cnt++;
            end
            if (cyc == 17) begin
                total_cnt++;
                if (dump_busy !== 1'b0 || dump_done !== 1'b0)
                    $display("FAIL dump_idle: busy=%b done=%b want 0 0", dump_busy, dump_done);
                else pass_cnt++;
            end
        end
        sb.delete();
    endtask

    task automatic test_backpressure();
        exp_t       e;
        int         xfers = 0, dones = 0, stall3 = 0;
        logic [3:0] pat = 4'b1001;
        logic [3:0] prev_idx = 4'd0;
        logic       prev_stall = 1'b0;
        logic       finished = 1'b0;
        model[3] = 32'hCAFE_F00D;
        push_all();
        step();
        dump_start = 1'b1; dump_ready = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            step();
            dump_start = (cyc == 5);
            we = 1'b0;
            if (dump_done === 1'b1) begin
                dones++;
                finished = 1'b1;
            end else if (dump_valid === 1'b1) begin
                if (prev_stall) begin
                    total_cnt++;
                    if (dump_idx !== prev_idx) $display("FAIL stall_hold: idx=%0d want %0d", dump_idx, prev_idx);
                    else pass_cnt++;
                end
                if (dump_idx == 4'd3 && stall3 < 2) begin
                    dump_ready = 1'b0;
                    stall3++;
                    if (stall3 == 1) begin
                        we = 1'b1; waddr = 4'd3; wdata = 32'hCAFE_F00D;
                    end
                end else begin
                    dump_ready = pat[cyc % 4];
                end
                #1;
                if (dump_ready) begin
                    total_cnt++;
                    if (sb.size() == 0) begin
                        $display("FAIL bp_extra: idx=%0d want no transfer", dump_idx);
                    end else begin
                        e = sb.pop_front();
                        if (dump_idx !== e.idx || dump_data !== e.data)
                            $display("FAIL bp_word: idx=%0d data=%h want idx=%0d data=%h", dump_idx, dump_data, e.idx, e.data);
                        else pass_cnt++;
                    end
                    xfers++;
                end
                prev_stall = !dump_ready;
                prev_idx   = dump_idx;
            end
        end
        total_cnt++;
        if (!finished || xfers != 16 || dones != 1 || stall3 != 2)
            $display("FAIL bp_total: finished=%b xfers=%0d dones=%0d stalls_at_3=%0d want 1 16 1 2", finished, xfers, dones, stall3);
        else pass_cnt++;
        step();
        dump_ready = 1'b1;
        #1;
        total_cnt++;
        if (dump_busy !== 1'b0) $display("FAIL bp_idle: busy=%b want 0", dump_busy);
        else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_reset_mid_dump();
        exp_t e;
        int   xfers = 0, dones = 0;
        logic found = 1'b0;
        step();
        dump_start = 1'b1; dump_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            step();
            dump_start = 1'b0;
            if (dump_valid === 1'b1 && dump_idx == 4'd7) found = 1'b1;
        end
        total_cnt++;
        if (!found) $display("FAIL mid_reach7: idx=%0d valid=%b want 7 1", dump_idx, dump_valid);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_idx !== 4'd0 || dump_done !== 1'b0)
            $display("FAIL mid_reset: busy=%b valid=%b idx=%0d done=%b want 0 0 0 0", dump_busy, dump_valid, dump_idx, dump_done);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (dump_done !== 1'b0) dones++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            if (dump_done !== 1'b0) dones++;
        end
        total_cnt++;
        if (dones != 0) $display("FAIL mid_no_done: done pulses=%0d want 0", dones);
        else pass_cnt++;
        push_all();
        dump_start = 1'b1;
        for (int cyc = 0; cyc < 40 && dones == 0; cyc++) begin
            step();
            dump_start = 1'b0;
            #1;
            if (dump_done === 1'b1) dones++;
            if (dump_valid === 1'b1) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL redump_extra: idx=%0d want no transfer", dump_idx);
                end else begin
                    e = sb.pop_front();
                    if (dump_idx !== e.idx || dump_data !== e.data)
                        $display("FAIL redump_word: idx=%0d data=%h want idx=%0d data=%h", dump_idx, dump_data, e.idx, e.data);
                    else pass_cnt++;
                end
                xfers++;
            end
        end
        total_cnt++;
        if (xfers != 16 || dones != 1) $display("FAIL redump_total: xfers=%0d dones=%0d want 16 1", xfers, dones);
        else pass_cnt++;
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = 4'd0; wdata = 32'h0;
        raddr_a = 4'd0; raddr_b = 4'd0; dump_start = 1'b0; dump_ready = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_r0();
        test_dump();
        test_backpressure();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
